db9md_joy_scanner: RTL and testbench

//  Scans two Sega Mega Drive style pads sharing one split-DB9 SNAC port and feeds the core's

---
 rtl/db9md_joy_scanner_if.sv | 29 ++
 rtl/db9md_joy_scanner.sv | 142 ++++++++++++++
 tb/tb_db9md_joy_scanner.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/db9md_joy_scanner_if.sv
// ============================================================================
// Module  : db9md_joy_scanner_if
// Brief   : Pad-line and decoded button bundle between the SNAC scanner and the joystick mux.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface db9md_joy_scanner_if;
    logic [5:0]  joy_in;
    logic        joy_mdsel;
    logic        joy_split;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic [1:0]  joy_type1;
    logic [1:0]  joy_type2;
    logic        scan_done;

    modport master (
        input  joy_in,
        output joy_mdsel, joy_split, joystick1, joystick2, joy_type1, joy_type2, scan_done
    );

    modport slave (
        output joy_in,
        input  joy_mdsel, joy_split, joystick1, joystick2, joy_type1, joy_type2, scan_done
    );
endinterface

`default_nettype wire

// File: rtl/db9md_joy_scanner.sv
// ============================================================================
// Module  : db9md_joy_scanner
// Brief   : Time-multiplexed scanner/decoder for two Mega Drive pads on one split-DB9 port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module db9md_joy_scanner #(
    parameter int TICK_DIV    = 400,
    parameter int IDLE_PHASES = 256
) (
    input  wire logic            clk_sys,
    input  wire logic            RESET,
    db9md_joy_scanner_if.master  bus
);

    localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_PH_MAX = (IDLE_PHASES > 8) ? IDLE_PHASES : 8;
    localparam int c_PH_W   = $clog2(c_PH_MAX);

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_PH_W-1:0]   c_IDLE_LAST = c_PH_W'(IDLE_PHASES - 1);
    localparam logic [c_PH_W-1:0]   c_PORT_LAST = c_PH_W'(7);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_P1   = 2'd1;
    localparam logic [1:0] c_ST_P2   = 2'd2;

    logic [5:0]          r_sync1, r_sync2;
    logic [c_TICK_W-1:0] r_tick;
    logic [c_PH_W-1:0]   r_phase;
    logic [1:0]          r_state;
    logic                r_mdsel, r_split;
    logic [11:0]         r_sh;
    logic                r_sh_present, r_sh_six;
    logic [15:0]         r_joy1, r_joy2;
    logic [1:0]          r_type1, r_type2;
    logic                r_done;

    logic                w_tick_last, w_phase_last, w_sample, w_commit;
    logic [1:0]          w_state_nxt;
    logic [c_PH_W-1:0]   w_phase_nxt;
    logic [5:0]          w_d;
    logic [15:0]         w_word;
    logic [1:0]          w_type;

    assign w_tick_last  = (r_tick == c_TICK_LAST);
    assign w_phase_last = (r_state == c_ST_IDLE) ? (r_phase == c_IDLE_LAST)
                                                 : (r_phase == c_PORT_LAST);
    assign w_sample     = w_tick_last && (r_state != c_ST_IDLE);
    assign w_commit     = w_sample && (r_phase == c_PORT_LAST);
    assign w_d          = ~r_sync2;

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        if (w_tick_last) begin
            if (w_phase_last) begin
                w_phase_nxt = '0;
                case (r_state)
                    c_ST_IDLE: w_state_nxt = c_ST_P1;
                    c_ST_P1:   w_state_nxt = c_ST_P2;
                    default:   w_state_nxt = c_ST_IDLE;
                endcase
            end else begin
                w_phase_nxt = r_phase + c_PH_W'(1);
            end
        end
    end

    // Masking is applied at commit so shadow bits captured before the type is known stay raw.
    assign w_word = {4'b0000,
                     r_sh[11:8] & {4{r_sh_six}},
                     r_sh[7:6]  & {2{r_sh_present}},
                     r_sh[5:0]};
    assign w_type = r_sh_six ? 2'd2 : (r_sh_present ? 2'd1 : 2'd0);

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            r_sync1      <= 6'h3F;
            r_sync2      <= 6'h3F;
            r_tick       <= '0;
            r_phase      <= '0;
            r_state      <= c_ST_IDLE;
            r_mdsel      <= 1'b1;
            r_split      <= 1'b0;
            r_sh         <= '0;
            r_sh_present <= 1'b0;
            r_sh_six     <= 1'b0;
            r_joy1       <= '0;
            r_joy2       <= '0;
            r_type1      <= '0;
            r_type2      <= '0;
            r_done       <= 1'b0;
        end else begin
            r_sync1 <= bus.joy_in;
            r_sync2 <= r_sync1;
            r_tick  <= w_tick_last ? '0 : r_tick + c_TICK_W'(1);
            r_phase <= w_phase_nxt;
            r_state <= w_state_nxt;
            // Pad lines are registered from the next state so TH and split change cleanly together.
            r_mdsel <= (w_state_nxt == c_ST_IDLE) || !w_phase_nxt[0];
            r_split <= (w_state_nxt == c_ST_P2);
            r_done  <= 1'b0;

            if (w_sample) begin
                case (r_phase[2:0])
                    3'd0: r_sh[5:0] <= {w_d[5], w_d[4], w_d[0], w_d[1], w_d[2], w_d[3]};
                    3'd1: begin
                        r_sh_present <= (r_sync2[3:2] == 2'b00);
                        r_sh[7:6]    <= {w_d[5], w_d[4]};
                    end
                    3'd5: r_sh_six   <= r_sh_present && (r_sync2[3:0] == 4'b0000);
                    3'd6: r_sh[11:8] <= {w_d[0], w_d[1], w_d[2], w_d[3]};
                    default: ;
                endcase
            end

            if (w_commit) begin
                if (r_state == c_ST_P1) begin
                    r_joy1  <= w_word;
                    r_type1 <= w_type;
                end else begin
                    r_joy2  <= w_word;
                    r_type2 <= w_type;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign bus.joy_mdsel = r_mdsel;
    assign bus.joy_split = r_split;
    assign bus.joystick1 = r_joy1;
    assign bus.joystick2 = r_joy2;
    assign bus.joy_type1 = r_type1;
    assign bus.joy_type2 = r_type2;
    assign bus.scan_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_db9md_joy_scanner.sv
// ============================================================================
// Module  : tb_db9md_joy_scanner
// Brief   : Self-checking bench with behavioural 3/6-button pad models on the shared port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_db9md_joy_scanner;

    localparam int c_TICK   = 8;
    localparam int c_IDLE   = 4;
    localparam int c_PERIOD = (16 + c_IDLE) * c_TICK;

    logic clk_sys = 1'b0;
    logic RESET   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    db9md_joy_scanner_if bus ();

    db9md_joy_scanner #(.TICK_DIV(c_TICK), .IDLE_PHASES(c_IDLE)) dut (
        .clk_sys (clk_sys),
        .RESET   (RESET),
        .bus     (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Pad configuration: kind 0 = static raw lines, 1 = three-button, 2 = six-button.
    int          kind1 = 0, kind2 = 0;
    logic [11:0] btn1 = '0, btn2 = '0;
    logic [5:0]  raw1 = 6'h3F, raw2 = 6'h3F;

    // Pad-side view of the TH sequence: index of the current select phase since the port opened.
    int   pk = 0;
    int   hi_cnt = 0;
    logic prev_sel = 1'b1, prev_split = 1'b0;

    always @(posedge clk_sys) begin
        prev_sel   <= bus.joy_mdsel;
        prev_split <= bus.joy_split;
        hi_cnt     <= bus.joy_mdsel ? hi_cnt + 1 : 0;
        if (bus.joy_split != prev_split)      pk <= 0;
        else if (bus.joy_mdsel != prev_sel)   pk <= (hi_cnt > 2 * c_TICK) ? 1 : pk + 1;
        else if (hi_cnt > 2 * c_TICK)         pk <= 0;
    end

    function automatic logic [5:0] pad_lines(int kind, logic [11:0] b, logic [5:0] raw, int k);
        logic [5:0] hi, lo;
        hi = ~{b[5], b[4], b[0], b[1], b[2], b[3]};
        lo = {~b[7], ~b[6], 2'b00, ~b[2], ~b[3]};
        if (kind == 0) return raw;
        if (kind == 1) return (k % 2 == 0) ? hi : lo;
        case (k)
            5:       return {~b[7], ~b[6], 4'b0000};
            6:       return {~b[5], ~b[4], ~b[8], ~b[9], ~b[10], ~b[11]};
            7:       return {~b[7], ~b[6], 4'b1111};
            default: return (k % 2 == 0) ? hi : lo;
        endcase
    endfunction

    always_comb begin
        bus.joy_in = bus.joy_split ? pad_lines(kind2, btn2, raw2, pk)
                                   : pad_lines(kind1, btn1, raw1, pk);
    end

    // Reference: what a completed scan reports for a given pad, as {type, word}.
    function automatic logic [17:0] model(int kind, logic [11:0] b, logic [5:0] raw);
        logic [5:0]  d;
        logic        pres, six;
        logic [15:0] w;
        if (kind == 1) return {2'd1, 8'h00, b[7:0]};
        if (kind == 2) return {2'd2, 4'h0, b};
        d    = ~raw;
        pres = (raw[3:2] == 2'b00);
        six  = pres && (raw[3:0] == 4'b0000);
        w    = '0;
        w[0] = d[3]; w[1] = d[2]; w[2] = d[1]; w[3] = d[0]; w[4] = d[4]; w[5] = d[5];
        if (pres) begin w[6] = d[4]; w[7] = d[5]; end
        if (six)  begin w[8] = d[3]; w[9] = d[2]; w[10] = d[1]; w[11] = d[0]; end
        return {six ? 2'd2 : (pres ? 2'd1 : 2'd0), w};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_done(string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2 * c_PERIOD + 10; i++) begin
            @(posedge clk_sys); #1;
            if (bus.scan_done) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: scan_done timeout, got 0, expected 1", name);
        end
    endtask

    task automatic check_outputs(string name, logic [15:0] e1, logic [1:0] t1,
                                 logic [15:0] e2, logic [1:0] t2);
        check({name, ".joystick1"}, 32'(bus.joystick1), 32'(e1));
        check({name, ".joy_type1"}, 32'(bus.joy_type1), 32'(t1));
        check({name, ".joystick2"}, 32'(bus.joystick2), 32'(e2));
        check({name, ".joy_type2"}, 32'(bus.joy_type2), 32'(t2));
    endtask

    typedef struct {
        int          k1; logic [11:0] b1; logic [5:0] r1;
        int          k2; logic [11:0] b2; logic [5:0] r2;
        logic [15:0] e1; logic [1:0]  t1;
        logic [15:0] e2; logic [1:0]  t2;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int low_cycles, pulses, run, split_cycles, done_cnt, done_at, n;
        logic prev, cur;
        logic [17:0] m1, m2;

        tbl[0] = '{1, 12'h048, 6'h3F, 0, 12'h000, 6'h3F, 16'h0048, 2'd1, 16'h0000, 2'd0};
        tbl[1] = '{0, 12'h000, 6'h3F, 2, 12'h301, 6'h3F, 16'h0000, 2'd0, 16'h0301, 2'd2};
        tbl[2] = '{0, 12'h000, 6'h3F, 0, 12'h000, 6'h3F, 16'h0000, 2'd0, 16'h0000, 2'd0};
        tbl[3] = '{0, 12'h000, 6'h3E, 0, 12'h000, 6'h3F, 16'h0008, 2'd0, 16'h0000, 2'd0};
        tbl[4] = '{2, 12'hFFF, 6'h3F, 1, 12'h0B0, 6'h3F, 16'h0FFF, 2'd2, 16'h00B0, 2'd1};
        tbl[5] = '{1, 12'h000, 6'h3F, 2, 12'h000, 6'h3F, 16'h0000, 2'd1, 16'h0000, 2'd2};

        // Reset state
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst.mdsel", 32'(bus.joy_mdsel), 32'd1);
        check("rst.split", 32'(bus.joy_split), 32'd0);
        check("rst.done",  32'(bus.scan_done), 32'd0);
        check_outputs("rst", 16'h0, 2'd0, 16'h0, 2'd0);
        RESET = 1'b0;

        // Scan timing over one full period
        wait_done("timing.first");
        low_cycles = 0; pulses = 0; run = 0; split_cycles = 0; done_cnt = 0; done_at = 0;
        prev = bus.joy_mdsel;
        for (int i = 1; i <= c_PERIOD; i++) begin
            @(posedge clk_sys); #1;
            cur = bus.joy_mdsel;
            if (!cur) begin low_cycles++; run++; end
            if (cur && !prev) begin
                pulses++;
                check("timing.low_width", 32'(run), 32'(c_TICK));
                run = 0;
            end
            if (bus.joy_split) split_cycles++;
            if (bus.scan_done) begin done_cnt++; done_at = i; end
            prev = cur;
        end
        check("timing.low_pulses",  32'(pulses),       32'd8);
        check("timing.low_cycles",  32'(low_cycles),   32'(8 * c_TICK));
        check("timing.split_high",  32'(split_cycles), 32'(8 * c_TICK));
        check("timing.done_count",  32'(done_cnt),     32'd1);
        check("timing.done_period", 32'(done_at),      32'(c_PERIOD));

        // Directed vectors
        for (int v = 0; v < 6; v++) begin
            kind1 = tbl[v].k1; btn1 = tbl[v].b1; raw1 = tbl[v].r1;
            kind2 = tbl[v].k2; btn2 = tbl[v].b2; raw2 = tbl[v].r2;
            wait_done("vec.settle");
            wait_done("vec.scan");
            check_outputs($sformatf("vec%0d", v), tbl[v].e1, tbl[v].t1, tbl[v].e2, tbl[v].t2);
        end

        // Randomized pads against the reference
        for (int it = 0; it < 12; it++) begin
            kind1 = int'($urandom_range(0, 2)); btn1 = 12'($urandom); raw1 = 6'($urandom);
            kind2 = int'($urandom_range(0, 2)); btn2 = 12'($urandom); raw2 = 6'($urandom);
            // A real 3-button pad cannot report Up and Down together.
            if (btn1[3] && btn1[2]) btn1[2] = 1'b0;
            if (btn2[3] && btn2[2]) btn2[2] = 1'b0;
            m1 = model(kind1, btn1, raw1);
            m2 = model(kind2, btn2, raw2);
            wait_done("rnd.settle");
            wait_done("rnd.scan");
            check_outputs($sformatf("rnd%0d", it), m1[15:0], m1[17:16], m2[15:0], m2[17:16]);
        end

        // C released on pad 1 after its first-phase sample
        kind1 = 2; btn1 = 12'h020; kind2 = 0; raw2 = 6'h3F;
        wait_done("rel.settle");
        wait_done("rel.scan0");
        check("rel.before", 32'(bus.joystick1), 32'h20);
        repeat (c_IDLE * c_TICK + c_TICK + 2) @(posedge clk_sys);
        btn1 = 12'h000;
        #1;
        check("rel.hold", 32'(bus.joystick1), 32'h20);
        wait_done("rel.scan1");
        check("rel.this_scan", 32'(bus.joystick1), 32'h20);
        check("rel.type",      32'(bus.joy_type1), 32'd2);
        wait_done("rel.scan2");
        check("rel.next_scan", 32'(bus.joystick1), 32'h0);

        // Reset during pad 1 phase 3
        kind1 = 1; btn1 = 12'h048; kind2 = 2; btn2 = 12'h301;
        wait_done("midrst.settle");
        wait_done("midrst.scan");
        check_outputs("midrst.pre", 16'h0048, 2'd1, 16'h0301, 2'd2);
        repeat (c_IDLE * c_TICK + 3 * c_TICK + 2) @(posedge clk_sys);
        RESET = 1'b1;
        @(posedge clk_sys); #1;
        check("midrst.mdsel", 32'(bus.joy_mdsel), 32'd1);
        check("midrst.split", 32'(bus.joy_split), 32'd0);
        check_outputs("midrst", 16'h0, 2'd0, 16'h0, 2'd0);
        repeat (2) @(posedge clk_sys);
        #1;
        RESET = 1'b0;
        n = 0;
        for (int i = 1; i <= 2 * c_PERIOD; i++) begin
            @(posedge clk_sys); #1;
            if (bus.scan_done) begin n = i; break; end
        end
        check("midrst.first_done", 32'(n), 32'(c_PERIOD));
        check_outputs("midrst.recover", 16'h0048, 2'd1, 16'h0301, 2'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
